// File: rtl/sevenseg_capture.sv
// sevenseg_capture: readback monitor for the multiplexed four-digit
// seven-segment bus. It waits for each digit slot to settle, decodes the
// segment pattern and publishes a complete frame d1..d4 atomically. It flags
// malformed patterns and out-of-order scanning on err.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic       frame_valid,
  output logic       err
);

  // Counter value one edge before it reaches STABLE_CYCLES-1; the accept
  // strobe is registered on the edge that performs that final increment.
  localparam logic [15:0] ACC_CNT = 16'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {EXP_L, EXP_ML, EXP_MR, EXP_R} state_t;

  // {valid, digit} for an active-low abcdefg pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: seg_decode = 5'h10;
      7'b1001111: seg_decode = 5'h11;
      7'b0010010: seg_decode = 5'h12;
      7'b0000110: seg_decode = 5'h13;
      7'b1001100: seg_decode = 5'h14;
      7'b0100100: seg_decode = 5'h15;
      7'b0100000: seg_decode = 5'h16;
      7'b0001111: seg_decode = 5'h17;
      7'b0000000: seg_decode = 5'h18;
      7'b0000100: seg_decode = 5'h19;
      default:    seg_decode = 5'h00;
    endcase
  endfunction

  // {one_hot_low, slot index} with LEFT = 0 ... RIGHT = 3.
  function automatic logic [2:0] slot_decode(input logic [3:0] a);
    case (a)
      4'b0111: slot_decode = 3'b100;
      4'b1011: slot_decode = 3'b101;
      4'b1101: slot_decode = 3'b110;
      4'b1110: slot_decode = 3'b111;
      default: slot_decode = 3'b000;
    endcase
  endfunction

  logic [3:0]  an_p0;
  logic [6:0]  seg_p0;
  logic [15:0] cnt_p0;
  logic        vld_p1;
  logic        chg;
  logic [4:0]  pat_p1;
  logic [2:0]  slot_p1;
  logic        pat_ok;
  logic [3:0]  digit;
  logic        slot_ok;
  logic [1:0]  slot;

  state_t state, state_nx;
  logic   ld1, ld2, ld3, ld_frm, err_nx;
  logic [3:0] s1, s2, s3;

  assign chg     = ({an, seg} != {an_p0, seg_p0});
  assign pat_p1  = seg_decode(seg_p0);
  assign slot_p1 = slot_decode(an_p0);
  assign pat_ok  = pat_p1[4];
  assign digit   = pat_p1[3:0];
  assign slot_ok = slot_p1[2];
  assign slot    = slot_p1[1:0];

  // ---- stage p0: input capture and stability counting ----
  // Register the bus and count consecutive identical samples (saturating).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an_p0  <= 4'b1111;
      seg_p0 <= 7'b1111111;
      cnt_p0 <= 16'd0;
      vld_p1 <= 1'b0;
    end else begin
      an_p0  <= an;
      seg_p0 <= seg;
      if (chg)
        cnt_p0 <= 16'd0;
      else if (cnt_p0 != 16'hFFFF)
        cnt_p0 <= cnt_p0 + 16'd1;
      vld_p1 <= !chg && (cnt_p0 == ACC_CNT);
    end
  end

  // ---- stage p1: slot sequencing on each accept ----
  // Scan-order state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= EXP_L;
    else     state <= state_nx;
  end

  // Classify the accepted slot and decide loads, completion and errors.
  always_comb begin
    state_nx = state;
    ld1      = 1'b0;
    ld2      = 1'b0;
    ld3      = 1'b0;
    ld_frm   = 1'b0;
    err_nx   = 1'b0;
    if (vld_p1) begin
      if (slot_ok) begin
        if (state_t'(slot) == state) begin
          if (pat_ok) begin
            case (state)
              EXP_L:   begin ld1 = 1'b1;    state_nx = EXP_ML; end
              EXP_ML:  begin ld2 = 1'b1;    state_nx = EXP_MR; end
              EXP_MR:  begin ld3 = 1'b1;    state_nx = EXP_R;  end
              default: begin ld_frm = 1'b1; state_nx = EXP_L;  end
            endcase
          end else begin
            err_nx   = 1'b1;
            state_nx = EXP_L;
          end
        end else begin
          // Out-of-order slot; a clean LEFT restarts the frame right away.
          err_nx = 1'b1;
          if (slot == 2'd0 && pat_ok) begin
            ld1      = 1'b1;
            state_nx = EXP_ML;
          end else begin
            state_nx = EXP_L;
          end
        end
      end else if (an_p0 != 4'b1111 && an_p0 != 4'b0000) begin
        err_nx   = 1'b1;
        state_nx = EXP_L;
      end
    end
  end

  // ---- stage p2: shadow digits, published frame and status pulses ----
  // Shadows collect a partial frame; d1..d4 move only on completion.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1          <= 4'd0;
      s2          <= 4'd0;
      s3          <= 4'd0;
      d1          <= 4'd0;
      d2          <= 4'd0;
      d3          <= 4'd0;
      d4          <= 4'd0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (ld1) s1 <= digit;
      if (ld2) s2 <= digit;
      if (ld3) s3 <= digit;
      if (ld_frm) begin
        d1 <= s1;
        d2 <= s2;
        d3 <= s3;
        d4 <= digit;
      end
      frame_valid <= ld_frm;
      err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scans plus random bus traffic, checked
// every cycle against a run-length/frame-assembly model of the capture rules.
module tb_sevenseg_capture;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] an  = 4'b1111;
  logic [6:0] seg = 7'b1111111;
  logic [3:0] d1, d2, d3, d4;
  logic       frame_valid, err;

  sevenseg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .clr(clr), .an(an), .seg(seg),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Digit glyphs (abcdefg, active low) and slot anode codes LEFT..RIGHT.
  logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};
  logic [3:0] SLOTAN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Reference model: length of the current run of identical samples, the
  // next slot position expected in the frame, collected digits and outputs.
  logic [10:0] m_reg;
  int          m_run;
  bit          m_acc;
  logic [10:0] m_acc_val;
  int          m_pos;
  int          m_sh [3];
  int          m_d  [4];
  bit          m_fv, m_err;

  function automatic int pat_digit(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (SLOTAN[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_reg = {4'b1111, 7'b1111111};
    m_run = 1;
    m_acc = 0;
    m_pos = 0;
    for (int i = 0; i < 3; i++) m_sh[i] = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
    m_fv  = 0;
    m_err = 0;
  endtask

  task automatic model_accept(input logic [10:0] v);
    int dg, sl;
    dg = pat_digit(v[6:0]);
    sl = slot_of(v[10:7]);
    if (v[10:7] == 4'b1111 || v[10:7] == 4'b0000) return;
    if (sl < 0) begin
      m_err = 1; m_pos = 0;
    end else if (sl == m_pos) begin
      if (dg < 0) begin
        m_err = 1; m_pos = 0;
      end else if (m_pos == 3) begin
        for (int i = 0; i < 3; i++) m_d[i] = m_sh[i];
        m_d[3] = dg;
        m_fv   = 1;
        m_pos  = 0;
      end else begin
        m_sh[m_pos] = dg;
        m_pos++;
      end
    end else begin
      m_err = 1;
      if (sl == 0 && dg >= 0) begin
        m_sh[0] = dg; m_pos = 1;
      end else begin
        m_pos = 0;
      end
    end
  endtask

  // One clock edge: act on the accept decided last edge, then sample the bus.
  task automatic model_edge(input logic [10:0] in);
    m_fv  = 0;
    m_err = 0;
    if (m_acc) model_accept(m_acc_val);
    m_acc = 0;
    if (in == m_reg) m_run++;
    else             m_run = 1;
    m_reg = in;
    if (m_run == S) begin
      m_acc     = 1;
      m_acc_val = in;
    end
  endtask

  task automatic cycle();
    logic [10:0] smp;
    @(posedge clk);
    smp = {an, seg};
    #1;
    model_edge(smp);
    chk("frame_valid", frame_valid, m_fv);
    chk("err", err, m_err);
    chk("d1", d1, m_d[0]);
    chk("d2", d2, m_d[1]);
    chk("d3", d3, m_d[2]);
    chk("d4", d4, m_d[3]);
    chk("fv_and_err", frame_valid & err, 0);
    fv_cnt  += int'(frame_valid);
    err_cnt += int'(err);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) cycle();
  endtask

  task automatic scan(input int a, input int b, input int c, input int d, input int n);
    hold(SLOTAN[0], PAT[a], n);
    hold(SLOTAN[1], PAT[b], n);
    hold(SLOTAN[2], PAT[c], n);
    hold(SLOTAN[3], PAT[d], n);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    model_reset();
    chk("clr_d1", d1, 0);
    chk("clr_d2", d2, 0);
    chk("clr_d3", d3, 0);
    chk("clr_d4", d4, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic chk_digits(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_d1"}, d1, a);
    chk({tag, "_d2"}, d2, b);
    chk({tag, "_d3"}, d3, c);
    chk({tag, "_d4"}, d4, d);
  endtask

  initial begin
    int idx;
    logic [3:0] ra;
    logic [6:0] rs;

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_digits("rst", 0, 0, 0, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_err", err, 0);
    clr = 1'b0;
    hold(4'b1111, 7'b1111111, 20);

    // Clean 1,2,3,4 frame.
    fv_cnt = 0; err_cnt = 0;
    scan(1, 2, 3, 4, 100);
    chk("scan1234_fv_cnt", fv_cnt, 1);
    chk("scan1234_err_cnt", err_cnt, 0);
    chk_digits("scan1234", 1, 2, 3, 4);
    hold(4'b1111, 7'b1111111, 30);

    // Short LEFT slot: never accepted; the next full frame still starts at LEFT.
    fv_cnt = 0; err_cnt = 0;
    hold(SLOTAN[0], PAT[7], 10);
    hold(4'b1111, 7'b1111111, 50);
    chk("short_err_cnt", err_cnt, 0);
    chk("short_fv_cnt", fv_cnt, 0);
    scan(4, 3, 2, 1, 40);
    chk_digits("after_short", 4, 3, 2, 1);
    scan(1, 2, 3, 4, 40);

    // Invalid MIDLEFT pattern, then a clean 6,7,8,9 frame.
    fv_cnt = 0; err_cnt = 0;
    hold(SLOTAN[0], PAT[5], 100);
    hold(SLOTAN[1], 7'b1111110, 100);
    chk("badpat_err_cnt", err_cnt, 1);
    chk_digits("badpat", 1, 2, 3, 4);
    scan(6, 7, 8, 9, 100);
    chk_digits("scan6789", 6, 7, 8, 9);
    chk("scan6789_fv_cnt", fv_cnt, 1);

    // Skipped slots, then LEFT arriving while MIDRIGHT is expected.
    fv_cnt = 0; err_cnt = 0;
    hold(SLOTAN[0], PAT[0], 100);
    hold(SLOTAN[3], PAT[3], 100);
    chk("skip_err_cnt", err_cnt, 1);
    hold(SLOTAN[0], PAT[1], 100);
    hold(SLOTAN[1], PAT[1], 100);
    hold(SLOTAN[0], PAT[2], 100);
    chk("resync_err_cnt", err_cnt, 2);
    hold(SLOTAN[1], PAT[5], 100);
    hold(SLOTAN[2], PAT[6], 100);
    hold(SLOTAN[3], PAT[7], 100);
    chk_digits("resync", 2, 5, 6, 7);
    chk("resync_fv_cnt", fv_cnt, 1);

    // Driver-reset anode code is ignored.
    fv_cnt = 0; err_cnt = 0;
    hold(4'b0000, 7'b0000000, 50);
    hold(4'b1111, 7'b1111111, 50);
    chk("an0000_err_cnt", err_cnt, 0);
    chk("an0000_fv_cnt", fv_cnt, 0);

    // clr in the middle of a 9,9,9,9 frame.
    fv_cnt = 0;
    hold(SLOTAN[0], PAT[9], 100);
    hold(SLOTAN[1], PAT[9], 100);
    hold(SLOTAN[2], PAT[9], 100);
    do_reset();
    hold(SLOTAN[3], PAT[9], 100);
    chk("clr_fv_cnt", fv_cnt, 0);
    chk_digits("after_clr", 0, 0, 0, 0);
    scan(1, 2, 3, 4, 100);
    chk_digits("post_clr_scan", 1, 2, 3, 4);
    chk("post_clr_fv_cnt", fv_cnt, 1);

    // Random traffic: mostly in-order slots with mixed hold lengths,
    // occasional bad anodes, bad patterns and blanking.
    idx = 0;
    for (int n = 0; n < 300; n++) begin
      ra = SLOTAN[idx];
      rs = PAT[$urandom_range(0, 9)];
      case ($urandom_range(0, 15))
        0:       ra = 4'($urandom());
        1:       rs = 7'($urandom());
        2:       ra = 4'b1111;
        3:       ra = SLOTAN[$urandom_range(0, 3)];
        default: ;
      endcase
      hold(ra, rs, ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1)
                                               : $urandom_range(S, 40));
      idx = (idx + 1) % 4;
    end
    hold(4'b1111, 7'b1111111, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side monitor for the multiplexed four-digit seven-segment bus that our display driver produces. Samples the anode and segment lines on the system clock, waits for each digit slot to settle, decodes the segment pattern back to a 4-bit digit and publishes a complete four-digit frame atomically. It sits next to the display driver in the clock design as a self-check and readback path, and flags malformed patterns or out-of-order digit scanning.

## Interface
- STABLE_CYCLES, 16: consecutive identical samples of {an,seg} required before a digit slot is accepted; legal range 2..65535.
- clk  input  1  system clock; all logic on rising edge.
- clr  input  1  asynchronous, active-high reset.
- an  input  4  anode lines, active low; 0111 = LEFT, 1011 = MIDLEFT, 1101 = MIDRIGHT, 1110 = RIGHT.
- seg  input  7  segment lines, active low, seg[6:0] = {a,b,c,d,e,f,g}.
- d1  output  4  decoded LEFT digit of the last complete frame.
- d2  output  4  decoded MIDLEFT digit.
- d3  output  4  decoded MIDRIGHT digit.
- d4  output  4  decoded RIGHT digit.
- frame_valid  output  1  one-cycle pulse when d1..d4 update.
- err  output  1  one-cycle pulse on a pattern or sequence error.

## Operation
- Input stage: an and seg are registered once into r_an and r_seg. Registers reset to an = 1111 and seg = 1111111.
- Stability counter: 16 bits, saturating. It clears to 0 on any edge where the newly registered {an,seg} differs from the previous registered value. Otherwise it increments. The internal accept strobe fires once, on the edge where the count reaches STABLE_CYCLES-1, so there is exactly one accept per stable period.
- Decode table, with seg given as abcdefg:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - Any other pattern is invalid.
- Anode classes on accept:
  - One-hot-low (one of the four slot codes): processed by the FSM.
  - 1111 (blank) and 0000 (driver reset): ignored, with no state change and no err.
  - Any other value: err pulse, FSM goes to EXP_L.
- FSM states: EXP_L, EXP_ML, EXP_MR, EXP_R. Reset state is EXP_L.
  - Expected slot with a valid pattern: the digit goes into shadow register s1/s2/s3, and the FSM advances to the next state.
  - In EXP_R with RIGHT and a valid pattern: d1..d3 load from s1..s3 and d4 loads the decoded digit, all on the same edge. frame_valid pulses and the FSM returns to EXP_L.
  - Expected slot with an invalid pattern: err pulse, FSM goes to EXP_L, no shadow or output update.
  - Unexpected slot code: err pulse.
    - If the slot is LEFT with a valid pattern, resynchronise: load s1 and go to EXP_ML.
    - Otherwise go to EXP_L.
  - In EXP_L, the MIDLEFT, MIDRIGHT and RIGHT slots count as unexpected.
- Outputs d1..d4 change only on frame completion. Partial frames are never visible.
- Reset values: d1..d4 = 0, frame_valid = 0, err = 0, shadows = 0, counter = 0, FSM = EXP_L.

## Timing
- Latency: an input change at clk edge k is registered at edge k+1. The accept strobe fires at edge k+STABLE_CYCLES. Shadow or d registers and the frame_valid/err pulses update at edge k+STABLE_CYCLES+1.
- frame_valid and err are registered and last exactly one cycle. They are never both high, because a completing RIGHT accept is always error-free.
- A slot held longer than STABLE_CYCLES produces a single accept. The saturated counter does not re-fire.
- A glitch shorter than STABLE_CYCLES restarts the count and produces no accept and no err.
- Asserting clr mid-frame discards the shadows immediately. d1..d4 return to 0 and the first frame after release must start at LEFT.
- Throughput: one frame per four accepts. No backpressure exists.

## Test plan
- Scan of digits 1,2,3,4 with STABLE_CYCLES=16, each slot held 100 cycles. Required: exactly one frame_valid, after which d1=1, d2=2, d3=3, d4=4. err never asserts.
- Slot held only 10 cycles, then changed to the next slot. Required: no accept from the short slot, no err, FSM state unchanged.
- Scan of LEFT=5, then MIDLEFT with seg=1111110 (invalid). Required: one err pulse, d1..d4 unchanged. A following clean 6,7,8,9 frame gives d1=6, d2=7, d3=8, d4=9.
- Scan of LEFT=0, then RIGHT=3 (skipped slots). Required: err pulse and FSM returns to EXP_L. Then LEFT=2 arriving in EXP_MR gives err, s1=2, FSM goes to EXP_ML, and the frame completes on the following MIDLEFT, MIDRIGHT and RIGHT slots.
- an=0000 with seg=0000000 for 50 cycles, then an=1111. Required: no err and no frame_valid.
- clr pulse after MIDRIGHT is accepted in a 9,9,9,9 scan. Required: d1..d4=0 immediately, no frame_valid for the interrupted frame, and the next full scan of 1,2,3,4 completes normally.
